// File: rtl/amm_master_qsys_with_pcie_reconf_sequencer_if.sv
// rtl/amm_master_qsys_with_pcie_reconf_sequencer_if.sv - table read port and reconfiguration write port bundle
//
// Groups the two bus-side ports of the reconfiguration sequencer:
//   tbl_*  : read port of the reconfiguration register RAM (registered output,
//            fixed read latency, no handshake)
//   rcfg_* : Avalon-MM style write port towards the transceiver reconfiguration
//            block (write held while waitrequest is high)
// master : sequencer side (drives addresses, write request)
// slave  : RAM / reconfiguration target side (drives read data, waitrequest)

interface amm_master_qsys_with_pcie_reconf_sequencer_if #(
    parameter int TABLE_AW = 7
);
    logic [TABLE_AW-1:0] tbl_address;
    logic                tbl_read;
    logic [31:0]         tbl_readdata;
    logic [13:0]         rcfg_address;
    logic [15:0]         rcfg_writedata;
    logic                rcfg_write;
    logic                rcfg_waitrequest;

    modport master (
        output tbl_address,
        output tbl_read,
        input  tbl_readdata,
        output rcfg_address,
        output rcfg_writedata,
        output rcfg_write,
        input  rcfg_waitrequest
    );

    modport slave (
        input  tbl_address,
        input  tbl_read,
        output tbl_readdata,
        input  rcfg_address,
        input  rcfg_writedata,
        input  rcfg_write,
        output rcfg_waitrequest
    );
endinterface

// File: rtl/amm_master_qsys_with_pcie_reconf_sequencer.sv
// rtl/amm_master_qsys_with_pcie_reconf_sequencer.sv - replays the reconfiguration table as Avalon-MM writes
//
// Walks the reconfiguration table from entry 0, replaying each entry:
//   [31:30] op  : 00 END, 01 WRITE, 10 WAIT, 11 reserved (error)
//   [29:16] rcfg address
//   [15:0]  write data or wait cycle count
// Ports:
//   clk, reset      : single clock, synchronous active-high reset
//   start           : one-cycle run request, honoured only when idle
//   busy            : run in progress (through the DONE/ERROR cycle)
//   done            : one-cycle pulse when an END entry finishes the run
//   error, err_addr : sticky error flag and the table address that caused it
//   bus (master)    : table read port and reconfiguration write port
// Every output is a flop; nothing from tbl_readdata or rcfg_waitrequest
// reaches an output without passing through a register.

module amm_master_qsys_with_pcie_reconf_sequencer #(
    parameter int TABLE_AW   = 7,
    parameter int RD_LATENCY = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [TABLE_AW-1:0] err_addr,
    amm_master_qsys_with_pcie_reconf_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WRITE,
        S_WAIT,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [1:0]          OP_END   = 2'b00;
    localparam logic [1:0]          OP_WRITE = 2'b01;
    localparam logic [1:0]          OP_WAIT  = 2'b10;
    localparam logic [TABLE_AW-1:0] PTR_LAST = '1;
    // FETCH counts down from RD_LATENCY so it lasts RD_LATENCY+1 cycles and
    // the entry is decoded on the edge where the RAM output is valid.
    localparam logic [15:0]         FETCH_CNT = 16'(RD_LATENCY);

    state_t              state_q, state_d;
    logic [TABLE_AW-1:0] ptr_q, ptr_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                error_d;
    logic [TABLE_AW-1:0] err_addr_d;
    logic [13:0]         rcfg_address_q, rcfg_address_d;
    logic [15:0]         rcfg_writedata_q, rcfg_writedata_d;
    logic                rcfg_write_q;
    logic                tbl_read_q;
    logic [TABLE_AW-1:0] tbl_address_q;
    logic                advance;

    assign bus.tbl_address    = tbl_address_q;
    assign bus.tbl_read       = tbl_read_q;
    assign bus.rcfg_address   = rcfg_address_q;
    assign bus.rcfg_writedata = rcfg_writedata_q;
    assign bus.rcfg_write     = rcfg_write_q;

    always_comb begin
        state_d          = state_q;
        ptr_d            = ptr_q;
        cnt_d            = cnt_q;
        error_d          = error;
        err_addr_d       = err_addr;
        rcfg_address_d   = rcfg_address_q;
        rcfg_writedata_d = rcfg_writedata_q;
        advance          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    ptr_d   = '0;
                    cnt_d   = FETCH_CNT;
                    error_d = 1'b0;
                end
            end
            S_FETCH: begin
                if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    case (bus.tbl_readdata[31:30])
                        OP_END: begin
                            state_d = S_DONE;
                        end
                        OP_WRITE: begin
                            state_d          = S_WRITE;
                            rcfg_address_d   = bus.tbl_readdata[29:16];
                            rcfg_writedata_d = bus.tbl_readdata[15:0];
                        end
                        OP_WAIT: begin
                            state_d = S_WAIT;
                            cnt_d   = bus.tbl_readdata[15:0];
                        end
                        default: begin
                            state_d    = S_ERROR;
                            error_d    = 1'b1;
                            err_addr_d = ptr_q;
                        end
                    endcase
                end
            end
            S_WRITE: begin
                if (!bus.rcfg_waitrequest) begin
                    advance = 1'b1;
                end
            end
            S_WAIT: begin
                // A count of n gives n+1 WAIT cycles: the zero cycle is included.
                if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    advance = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERROR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Running off the end of the table without an END entry is an error
        // on the last entry; the pointer is never allowed to wrap.
        if (advance) begin
            if (ptr_q == PTR_LAST) begin
                state_d    = S_ERROR;
                error_d    = 1'b1;
                err_addr_d = ptr_q;
            end else begin
                state_d = S_FETCH;
                ptr_d   = ptr_q + TABLE_AW'(1);
                cnt_d   = FETCH_CNT;
            end
        end
    end

    // Outputs are registered from the next-state decode so they line up with
    // the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_IDLE;
            ptr_q            <= '0;
            cnt_q            <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            error            <= 1'b0;
            err_addr         <= '0;
            tbl_address_q    <= '0;
            tbl_read_q       <= 1'b0;
            rcfg_address_q   <= '0;
            rcfg_writedata_q <= '0;
            rcfg_write_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            ptr_q            <= ptr_d;
            cnt_q            <= cnt_d;
            busy             <= (state_d != S_IDLE);
            done             <= (state_d == S_DONE);
            error            <= error_d;
            err_addr         <= err_addr_d;
            tbl_address_q    <= ptr_d;
            tbl_read_q       <= (state_d == S_FETCH);
            rcfg_address_q   <= rcfg_address_d;
            rcfg_writedata_q <= rcfg_writedata_d;
            rcfg_write_q     <= (state_d == S_WRITE);
        end
    end

endmodule
